// File: rtl/adder_tree_feeder_if.sv
// Handshake bundle between the operand stream, the feeder and the adder tree.
// The in_last signal and its modport entries exist only when FEEDER_FLUSH_EN
// is defined.
interface adder_tree_feeder_if #(
    parameter int WIDTH = 32,
    parameter int N     = 128
);
    localparam int CW = $clog2(N) + 1;

    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data;
`ifdef FEEDER_FLUSH_EN
    logic                    in_last;
`endif
    logic                    vec_valid;
    logic                    vec_ready;
    logic signed [WIDTH-1:0] vec_data [0:N-1];
    logic [CW-1:0]           vec_count;

`ifdef FEEDER_FLUSH_EN
    // Master: operand source plus vector consumer.
    modport master (
        output in_valid, in_data, in_last, vec_ready,
        input  in_ready, vec_valid, vec_data, vec_count
    );
    // Slave: the feeder itself.
    modport slave (
        input  in_valid, in_data, in_last, vec_ready,
        output in_ready, vec_valid, vec_data, vec_count
    );
`else
    modport master (
        output in_valid, in_data, vec_ready,
        input  in_ready, vec_valid, vec_data, vec_count
    );
    modport slave (
        input  in_valid, in_data, vec_ready,
        output in_ready, vec_valid, vec_data, vec_count
    );
`endif
endinterface

// File: rtl/adder_tree_feeder.sv
// Ping-pong feeder for the N-input adder tree. A serial stream of signed
// operands fills one bank while the other bank is held for the tree.
// Optional feature: define FEEDER_FLUSH_EN to add in_last, which commits a
// short vector early; unused slots stay zero so the tree sum is unaffected.

// One vector element position, holding that position for both banks.
module adder_tree_feeder_slot #(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              wr_en,
    input  logic [1:0]              clr,
    input  logic signed [WIDTH-1:0] wr_data,
    input  logic                    rd_sel,
    output logic signed [WIDTH-1:0] rd_data
);
    logic signed [WIDTH-1:0] ent [2];

    // Release clears the entry so short vectors read zero in unwritten slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) ent[b] <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (clr[b])        ent[b] <= '0;
                else if (wr_en[b]) ent[b] <= wr_data;
            end
        end
    end

    assign rd_data = ent[rd_sel];
endmodule

module adder_tree_feeder #(
    parameter int WIDTH = 32,
    parameter int N     = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    adder_tree_feeder_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int CW = IW + 1;

    logic [1:0]    bank_full;
    logic [1:0]    bank_full_nxt;
    logic          wr_sel;
    logic          rd_sel;
    logic [IW-1:0] wr_idx;
    logic [CW-1:0] count [2];

    logic accept;
    logic commit;
    logic rd_fire;
    logic last_hit;

`ifdef FEEDER_FLUSH_EN
    assign last_hit = bus.in_last;
`else
    assign last_hit = 1'b0;
`endif

    // in_ready depends on registers only, never on in_valid.
    assign bus.in_ready  = ~bank_full[wr_sel];
    assign accept        = bus.in_valid & bus.in_ready;
    assign commit        = accept & ((wr_idx == IW'(N - 1)) | last_hit);
    assign rd_fire       = bank_full[rd_sel] & bus.vec_ready;

    assign bus.vec_valid = bank_full[rd_sel];
    assign bus.vec_count = count[rd_sel];

    // Commit and release always target different banks, so both may apply.
    always_comb begin
        bank_full_nxt = bank_full;
        if (rd_fire) bank_full_nxt[rd_sel] = 1'b0;
        if (commit)  bank_full_nxt[wr_sel] = 1'b1;
    end

    // Bank state, pointers and per-bank element counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full <= '0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            wr_idx    <= '0;
            count[0]  <= '0;
            count[1]  <= '0;
        end else begin
            bank_full <= bank_full_nxt;
            if (rd_fire) begin
                rd_sel        <= ~rd_sel;
                count[rd_sel] <= '0;
            end
            if (commit) begin
                wr_sel        <= ~wr_sel;
                wr_idx        <= '0;
                count[wr_sel] <= CW'(wr_idx) + CW'(1);
            end else if (accept) begin
                wr_idx <= wr_idx + IW'(1);
            end
        end
    end

    // Element storage: one slot instance per vector position.
    for (genvar i = 0; i < N; i++) begin : g_slot
        logic [1:0] wr_en;
        logic [1:0] clr;
        logic       hit;

        assign hit   = accept & (wr_idx == IW'(i));
        assign wr_en = {hit & wr_sel, hit & ~wr_sel};
        assign clr   = {rd_fire & rd_sel, rd_fire & ~rd_sel};

        adder_tree_feeder_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en),
            .clr     (clr),
            .wr_data (bus.in_data),
            .rd_sel  (rd_sel),
            .rd_data (bus.vec_data[i])
        );
    end
endmodule

// File: tb/tb_adder_tree_feeder.sv
// Self-checking bench for adder_tree_feeder: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// queue-based model of the stream-to-vector packing.
module tb_adder_tree_feeder;
    localparam int WIDTH = 32;
    localparam int N     = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_tree_feeder_if #(.WIDTH(WIDTH), .N(N)) bus ();

    adder_tree_feeder #(.WIDTH(WIDTH), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: operands of the vector being filled, and completed vectors
    // waiting for the tree (at most two), flattened with their counts.
    logic signed [WIDTH-1:0] part [$];
    logic signed [WIDTH-1:0] pend_data [$];
    int                      pend_cnt [$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint dut_sum();
        longint s = 0;
        for (int i = 0; i < N; i++) s += longint'(bus.vec_data[i]);
        return s;
    endfunction

    function automatic longint model_elem(input int i);
        if (pend_cnt.size() > 0) return (i < pend_cnt[0]) ? longint'(pend_data[i]) : 0;
        return (i < part.size()) ? longint'(part[i]) : 0;
    endfunction

    // Model update on each accepted edge; reset empties everything.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part.delete();
            pend_data.delete();
            pend_cnt.delete();
        end else begin
            bit acc, fire, last;
            acc  = bus.in_valid && (pend_cnt.size() < 2);
            fire = bus.vec_ready && (pend_cnt.size() > 0);
`ifdef FEEDER_FLUSH_EN
            last = bus.in_last;
`else
            last = 1'b0;
`endif
            if (fire) begin
                for (int i = 0; i < pend_cnt[0]; i++) void'(pend_data.pop_front());
                void'(pend_cnt.pop_front());
            end
            if (acc) begin
                part.push_back(bus.in_data);
                if (part.size() == N || last) begin
                    pend_cnt.push_back(part.size());
                    foreach (part[i]) pend_data.push_back(part[i]);
                    part.delete();
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            int bad;
            bad = -1;
            chk("in_ready", longint'(bus.in_ready), (pend_cnt.size() < 2) ? 1 : 0);
            chk("vec_valid", longint'(bus.vec_valid), (pend_cnt.size() > 0) ? 1 : 0);
            chk("vec_count", longint'(bus.vec_count), (pend_cnt.size() > 0) ? pend_cnt[0] : 0);
            for (int i = 0; i < N; i++)
                if (bad < 0 && longint'(bus.vec_data[i]) != model_elem(i)) bad = i;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL vec_data[%0d] actual %0d expected %0d at %0t",
                         bad, longint'(bus.vec_data[bad]), model_elem(bad), $time);
            end
        end
    end

    // Present one operand and hold it until the edge that accepts it.
    task automatic push(input logic signed [WIDTH-1:0] v, input bit last);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
`ifdef FEEDER_FLUSH_EN
        bus.in_last  = last;
`else
        if (last) guard = 0;
`endif
        while (!bus.in_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 1000) begin
                chk("push_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
`ifdef FEEDER_FLUSH_EN
            bus.in_last  = 1'b0;
`endif
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.vec_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_vec_valid"}, longint'(bus.vec_valid), 0);
        chk({tag, "_in_ready"}, longint'(bus.in_ready), 1);
        chk({tag, "_vec_count"}, longint'(bus.vec_count), 0);
        chk({tag, "_vec_sum0"}, dut_sum(), 0);
        chk({tag, "_vec_data0"}, longint'(bus.vec_data[0]), 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.vec_ready = 1'b0;
`ifdef FEEDER_FLUSH_EN
        bus.in_last   = 1'b0;
`endif
        #1;
        chk_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // 1..128 back-to-back with the tree always ready.
        bus.vec_ready = 1'b1;
        for (int k = 1; k < N; k++) push(k, 1'b0);
        @(negedge clk);
        chk("t1_pre_valid", longint'(bus.vec_valid), 0);
        bus.in_data = N;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("t1_valid", longint'(bus.vec_valid), 1);
        chk("t1_d0", longint'(bus.vec_data[0]), 1);
        chk("t1_d127", longint'(bus.vec_data[N-1]), 128);
        chk("t1_sum", dut_sum(), 8256);
        chk("t1_count", longint'(bus.vec_count), 128);
        @(negedge clk);
        chk("t1_drop", longint'(bus.vec_valid), 0);

        // Both banks fill with the tree stalled; 257 waits on the input.
        bus.vec_ready = 1'b0;
        for (int k = 1; k <= 2 * N; k++) push(k, 1'b0);
        @(negedge clk);
        bus.in_data = 257;
        chk("t2_stall", longint'(bus.in_ready), 0);
        idle(0);
        repeat (3) @(negedge clk);
        chk("t2_hold_d0", longint'(bus.vec_data[0]), 1);
        chk("t2_hold_ready", longint'(bus.in_ready), 0);
        bus.vec_ready = 1'b1;
        @(negedge clk);
        bus.vec_ready = 1'b0;
        chk("t2_next_d0", longint'(bus.vec_data[0]), 129);
        chk("t2_ready_back", longint'(bus.in_ready), 1);
        @(posedge clk);
        for (int k = 258; k <= 300; k++) push(k, 1'b0);
        idle(1);
        bus.vec_ready = 1'b1;
        idle(4);

        // All-ones operands keep their sign.
        do_reset();
        for (int k = 0; k < N; k++) push(-1, 1'b0);
        idle(1);
        chk("t3_d5", longint'(bus.vec_data[5]), -1);
        chk("t3_raw", longint'($unsigned(bus.vec_data[N-1])), 64'hFFFF_FFFF);
        chk("t3_sum", dut_sum(), -128);
        bus.vec_ready = 1'b1;
        idle(2);

        // Reset in the middle of a fill discards it immediately.
        bus.vec_ready = 1'b0;
        for (int k = 0; k < 50; k++) push($urandom_range(1, 1000), 1'b0);
        idle(1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("t4");
        #9 rst_n = 1'b1;
        for (int k = 0; k < N; k++) push(7, 1'b0);
        idle(1);
        chk("t4_valid", longint'(bus.vec_valid), 1);
        chk("t4_count", longint'(bus.vec_count), 128);
        chk("t4_sum", dut_sum(), 7 * 128);
        bus.vec_ready = 1'b1;
        idle(2);

        // Release of bank A on the same edge that completes bank B.
        do_reset();
        for (int k = 0; k < N; k++) push(1000 + k, 1'b0);
        for (int k = 0; k < N - 1; k++) push(2000 + k, 1'b0);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = 2000 + N - 1;
        bus.vec_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.vec_ready = 1'b0;
        chk("t5_valid", longint'(bus.vec_valid), 1);
        chk("t5_d0", longint'(bus.vec_data[0]), 2000);
        chk("t5_ready", longint'(bus.in_ready), 1);

`ifdef FEEDER_FLUSH_EN
        // Short vector flushed by in_last.
        do_reset();
        push(5, 1'b0);
        push(-3, 1'b0);
        push(9, 1'b1);
        idle(1);
        chk("t6_valid", longint'(bus.vec_valid), 1);
        chk("t6_count", longint'(bus.vec_count), 3);
        chk("t6_d1", longint'(bus.vec_data[1]), -3);
        chk("t6_d3", longint'(bus.vec_data[3]), 0);
        chk("t6_sum", dut_sum(), 11);
        bus.vec_ready = 1'b1;
        idle(2);
`endif

        // Randomized traffic, checked every cycle by the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = $urandom;
            bus.vec_ready = ($urandom_range(0, 2) == 0);
`ifdef FEEDER_FLUSH_EN
            bus.in_last   = ($urandom_range(0, 19) == 0);
`endif
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder_tree_feeder.md
Name: adder_tree_feeder

Overview:
- Producer-side front end for the 128-input adder tree: accepts a serial stream of signed WIDTH-bit operands over a valid/ready handshake and packs them into an N-element vector.
- The vector is presented with a valid/ready handshake to the combinational reduction tree.
- Ping-pong double buffering lets one bank fill while the other is held for the tree, so the stream sustains one operand per cycle.

Parameters:
- WIDTH, 32, bit width of each signed operand and vector element.
- N, 128, elements per vector; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  feeder can accept in_data this cycle.
- in_data  input  WIDTH signed  operand stream.
- in_last  input  1  present only with FEEDER_FLUSH_EN; marks the final operand of a short vector.
- vec_valid  output  1  vec_data holds a complete vector.
- vec_ready  input  1  downstream consumes the vector this cycle.
- vec_data  output  WIDTH signed x N, unpacked array [0:N-1]  packed vector; element 0 is the first operand accepted.
- vec_count  output  $clog2(N)+1  number of written elements in vec_data: N, or fewer on a flush.

Behaviour:
- Reset (async assert, sync release): bank_full[1:0]=0, wr_sel=0, rd_sel=0, wr_idx=0, all bank entries=0, per-bank counts=0. Resulting outputs: vec_valid=0, vec_data all 0, vec_count=0, in_ready=1.
- Resetting mid-fill or while holding a vector discards all data. No partial vector is emitted.
- State per bank: EMPTY/FILLING (bank_full=0) or FULL (bank_full=1).
- Write side:
  - in_ready = !bank_full[wr_sel] (combinational from registers only; no path from in_valid).
  - On accept (in_valid & in_ready): bank[wr_sel][wr_idx] <= in_data, then wr_idx++.
  - Accepting at wr_idx==N-1 commits the bank: bank_full[wr_sel]=1, count[wr_sel]=N, wr_sel toggles, wr_idx=0.
- Read side:
  - vec_valid = bank_full[rd_sel]; vec_data = bank[rd_sel]; vec_count = count[rd_sel].
  - On vec_valid & vec_ready: bank_full[rd_sel]=0, all entries of that bank cleared to 0, rd_sel toggles.
- Latency: the vector is valid the cycle after its last operand is accepted.
- Throughput: one vector per N cycles with no stalls.
- vec_data/vec_count must be stable while vec_valid=1 and vec_ready=0.
- Both banks full: in_ready=0. The stream stalls; no element is dropped or overwritten.
- Simultaneous commit of one bank and release of the other in the same cycle: both updates take effect.
- If rd_sel bank is released and wr_sel points at it, in_ready rises the next cycle.
- Arithmetic: none; elements are stored bit-exact. Sign is preserved for the signed tree.
- wr_idx wraps N-1 -> 0 only on commit.

Optional Feature:
- Macro: FEEDER_FLUSH_EN.
- Defined:
  - in_last port exists.
  - Accepting an operand with in_last=1 at wr_idx=k (k<N-1) commits the bank early with count=k+1 and toggles wr_sel.
  - Slots k+1..N-1 read as 0, because banks are zero-cleared on release/reset, so the tree sum is correct.
  - in_last at wr_idx==N-1 behaves as a normal full commit.
  - in_last is ignored when not accepted.
- Undefined:
  - No in_last port.
  - Only full N-element vectors are emitted.
  - vec_count is always N when vec_valid=1, and 0 otherwise.

Test Plan:
- Stream 1..128 back-to-back, vec_ready=1 -> vec_valid high exactly one cycle after the 128th accept; vec_data[0]=1, vec_data[127]=128; tree sum 8256; vec_valid drops after the handshake.
- vec_ready=0, stream 300 values 1..300 -> in_ready falls after the 256th accept; value 257 held on input. Pulse vec_ready -> vector 1..128 consumed; next cycle vec_data[0]=129; in_ready=1; value 257 accepted.
- 128 copies of -1 (0xFFFFFFFF) -> all elements 0xFFFFFFFF; tree sum -128.
- Accept 50 values, assert rst_n=0 for one cycle mid-clock -> outputs go to reset values immediately; then 128 values of 7 -> one vector of all 7, vec_count=128.
- Release bank A with vec_ready on the same cycle the 128th element of bank B is accepted -> next cycle vec_valid=1 with bank B data; in_ready=1; no bubble lost.
- FEEDER_FLUSH_EN: values 5, -3, 9 with in_last on 9 -> vec_valid, vec_count=3, vec_data[0..2]=5,-3,9, vec_data[3..127]=0, tree sum 11.
